// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with a 3-flop rx synchronizer and a 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to add one parity bit per frame (PARITY_ODD picks odd/even).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, baud counter held at 0, waiting for a falling edge
// START     | validating the start bit; a high vote is a glitch
// DATA      | shifting in DATA_BITS votes, LSB first
// PARITY    | capturing the parity vote (parity build only)
// STOP      | capturing STOP_BITS votes; the last one closes the frame
// WAIT_IDLE | line still low after the frame (break), waiting for it to rise
module uart_rx_param #(
  parameter int CLK_FREQ   = 96_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int MID          = BAUD_CNT_MAX / 2 - 1;
  localparam int CW           = $clog2(BAUD_CNT_MAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  // An illegal parameter set leaves the receiver parked in IDLE.
  localparam bit CFG_OK = (DATA_BITS >= 5) && (DATA_BITS <= 8) &&
                          (STOP_BITS == 1 || STOP_BITS == 2) &&
                          (PARITY_ODD == 0 || PARITY_ODD == 1) &&
                          (BAUD_CNT_MAX >= 8);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;
`endif

  state_t state, state_next;

  logic rx_s1, rx_s2, rx_sync, rx_d;
  logic fall_edge;
  logic [CW-1:0] baud_cnt;
  logic samp_a, samp_b, samp_tick, vote;
  logic [2:0] bit_cnt;
  logic bit_last;
  logic [DATA_BITS-1:0] shift_reg;
  logic stop_bad, first_stop, stop1_vote;
  logic shift_en, stop_en, frame_done;
  logic par_zero;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_sync <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_sync <= rx_s2;
      rx_d    <= rx_sync;
    end
  end

  assign fall_edge = rx_d & ~rx_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == S_IDLE) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  // Two early samples are stored; the third is the live synchronized line.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (baud_cnt == CNT_S0) samp_a <= rx_sync;
      if (baud_cnt == CNT_S1) samp_b <= rx_sync;
    end
  end

  assign samp_tick = (state != S_IDLE) && (baud_cnt == CNT_S2);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign bit_last  = (state == S_DATA) ? (bit_cnt == DATA_LAST) : (bit_cnt == STOP_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == S_IDLE) begin
      bit_cnt <= '0;
    end else if (samp_tick && (state == S_DATA || state == S_STOP)) begin
      bit_cnt <= bit_last ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (fall_edge && CFG_OK) state_next = S_START;
      S_START:     if (samp_tick) state_next = vote ? S_IDLE : S_DATA;
      S_DATA: begin
        if (samp_tick && bit_last) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:    if (samp_tick) state_next = S_STOP;
`endif
      S_STOP:      if (samp_tick && bit_last) state_next = rx_sync ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_sync) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
`endif

  always_comb begin
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state)
      S_DATA:   shift_en = samp_tick;
`ifdef UART_RX_PARITY_EN
      S_PARITY: par_en   = samp_tick;
`endif
      S_STOP: begin
        stop_en    = samp_tick;
        frame_done = samp_tick & bit_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == S_START) begin
      stop_bad   <= 1'b0;
      first_stop <= 1'b1;
    end else if (stop_en) begin
      if (!vote) stop_bad <= 1'b1;
      if (bit_cnt == 3'd0) first_stop <= vote;
    end
  end

  // With one stop bit the first stop vote is the one being taken right now.
  assign stop1_vote = (bit_cnt == 3'd0) ? vote : first_stop;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic parity_bit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      parity_bit <= 1'b0;
    end else if (par_en) begin
      parity_bit <= vote;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= frame_done & (^shift_reg ^ parity_bit ^ PAR_ODD);
    end
  end

  assign par_zero = ~parity_bit;
`else
  assign parity_err = 1'b0;
  assign par_zero   = 1'b1;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      po_flag   <= frame_done;
      frame_err <= frame_done & (stop_bad | ~vote);
      break_det <= frame_done & ~(|shift_reg) & ~stop1_vote & par_zero;
      if (frame_done) po_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and a 5-data/2-stop instance,
// frames built from plain bit lists and checked against a rule-level model.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1_958_450;
  localparam int UART_BPS = 115200;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int A_BITS = 8, A_STOP = 1, A_ODD = 0;
  localparam int B_BITS = 5, B_STOP = 2, B_ODD = 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       bd;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] po_data_a;
  logic [4:0] po_data_b;
  logic flag_a, fe_a, pe_a, bd_a;
  logic flag_b, fe_b, pe_b, bd_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int vectors = 0;
  int miscompares = 0;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(A_BITS),
                  .STOP_BITS(A_STOP), .PARITY_ODD(A_ODD)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx_a), .po_data(po_data_a),
    .po_flag(flag_a), .frame_err(fe_a), .parity_err(pe_a), .break_det(bd_a));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(B_BITS),
                  .STOP_BITS(B_STOP), .PARITY_ODD(B_ODD)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx_b), .po_data(po_data_b),
    .po_flag(flag_b), .frame_err(fe_b), .parity_err(pe_b), .break_det(bd_b));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result straight from the frame content and the receiver's rules.
  function automatic exp_t model(input int nstop, input int odd, input logic [7:0] d,
                                 input logic p, input logic [1:0] stops);
    exp_t e;
    e.data = d;
    e.fe   = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    e.pe   = PAR_EN && ((($countones(d) + int'(p)) % 2) != odd);
    e.bd   = (d == 8'h00) && (!PAR_EN || !p) && !stops[0];
    return e;
  endfunction

  task automatic put_bit(input int sel, input logic v);
    @(negedge sys_clk);
    if (sel == 0) rx_a = v;
    else rx_b = v;
    repeat (BIT - 1) @(negedge sys_clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input logic par_flip,
                            input logic [1:0] stops);
    int nbits, nstop, odd;
    logic [7:0] d;
    logic p;
    nbits = (sel == 0) ? A_BITS : B_BITS;
    nstop = (sel == 0) ? A_STOP : B_STOP;
    odd   = (sel == 0) ? A_ODD : B_ODD;
    d = data & 8'((1 << nbits) - 1);
    p = 1'(($countones(d) + odd) % 2) ^ par_flip;
    if (sel == 0) q_a.push_back(model(nstop, odd, d, p, stops));
    else q_b.push_back(model(nstop, odd, d, p, stops));
    put_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) put_bit(sel, d[i]);
    if (PAR_EN) put_bit(sel, p);
    for (int i = 0; i < nstop; i++) put_bit(sel, stops[i]);
    put_bit(sel, 1'b1);
  endtask

  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] last_a = 8'h00;
  logic [4:0] last_b = 5'h00;

  always @(negedge sys_clk) begin
    exp_t e;
    if (flag_a === 1'b1) begin
      check("flag_a_single_cycle", 32'(prev_a), 32'd0);
      if (q_a.size() == 0) begin
        check("flag_a_unexpected_data", 32'(po_data_a), 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        check("data_a", 32'(po_data_a), 32'(e.data));
        check("frame_err_a", 32'(fe_a), 32'(e.fe));
        check("parity_err_a", 32'(pe_a), 32'(e.pe));
        check("break_det_a", 32'(bd_a), 32'(e.bd));
      end
      last_a = po_data_a;
    end else if (sys_rst) begin
      last_a = po_data_a;
    end else if (!$isunknown(po_data_a)) begin
      if ({fe_a, pe_a, bd_a} != 3'b000) check("flags_a_idle", 32'({fe_a, pe_a, bd_a}), 32'd0);
      if (po_data_a != last_a) check("data_a_hold", 32'(po_data_a), 32'(last_a));
    end
    prev_a = flag_a;
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (flag_b === 1'b1) begin
      check("flag_b_single_cycle", 32'(prev_b), 32'd0);
      if (q_b.size() == 0) begin
        check("flag_b_unexpected_data", 32'(po_data_b), 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        check("data_b", 32'(po_data_b), 32'(e.data));
        check("frame_err_b", 32'(fe_b), 32'(e.fe));
        check("parity_err_b", 32'(pe_b), 32'(e.pe));
        check("break_det_b", 32'(bd_b), 32'(e.bd));
      end
      last_b = po_data_b;
    end else if (sys_rst) begin
      last_b = po_data_b;
    end else if (!$isunknown(po_data_b)) begin
      if ({fe_b, pe_b, bd_b} != 3'b000) check("flags_b_idle", 32'({fe_b, pe_b, bd_b}), 32'd0);
      if (po_data_b != last_b) check("data_b_hold", 32'(po_data_b), 32'(last_b));
    end
    prev_b = flag_b;
  end

  task automatic check_reset_outputs();
    check("rst_data_a", 32'(po_data_a), 32'd0);
    check("rst_flags_a", 32'({flag_a, fe_a, pe_a, bd_a}), 32'd0);
    check("rst_data_b", 32'(po_data_b), 32'd0);
    check("rst_flags_b", 32'({flag_b, fe_b, pe_b, bd_b}), 32'd0);
  endtask

  initial begin
    int t;
    logic [7:0] d;
    logic [1:0] st;
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst = 1'b0;
    put_bit(0, 1'b1);
    put_bit(0, 1'b1);

    send_frame(0, 8'hA5, 1'b0, 2'b11);
    send_frame(0, 8'h03, 1'b1, 2'b11);
    send_frame(0, 8'h03, 1'b0, 2'b11);
    send_frame(0, 8'h5A, 1'b0, 2'b10);
    send_frame(0, 8'h11, 1'b0, 2'b11);

    // held break: one frame of zeros, then the line rises
    q_a.push_back(model(A_STOP, A_ODD, 8'h00, 1'b0, 2'b00));
    @(negedge sys_clk);
    rx_a = 1'b0;
    repeat (20 * BIT - 1) @(negedge sys_clk);
    put_bit(0, 1'b1);
    put_bit(0, 1'b1);

    // short glitches must not produce frames
    @(negedge sys_clk);
    rx_a = 1'b0;
    repeat (4) @(negedge sys_clk);
    rx_a = 1'b1;
    put_bit(0, 1'b1);
    @(negedge sys_clk);
    rx_a = 1'b0;
    @(negedge sys_clk);
    rx_a = 1'b1;
    put_bit(0, 1'b1);

    // reset in the middle of bit 3 of 0xFF aborts the frame
    put_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) put_bit(0, 1'b1);
    @(negedge sys_clk);
    rx_a = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) put_bit(0, 1'b1);
    send_frame(0, 8'h42, 1'b0, 2'b11);

    send_frame(1, 8'h15, 1'b0, 2'b11);
    send_frame(1, 8'h15, 1'b0, 2'b01);
    send_frame(1, 8'h00, 1'b0, 2'b00);
    send_frame(1, 8'h0A, 1'b1, 2'b10);

    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      st = 2'b11;
      if ($urandom_range(0, 3) == 0) st[0] = 1'b0;
      if ($urandom_range(0, 3) == 0) st[1] = 1'b0;
      send_frame(n % 2, d, 1'($urandom_range(0, 1)), st);
      repeat ($urandom_range(0, 2)) put_bit(n % 2, 1'b1);
    end

    t = 0;
    while ((q_a.size() + q_b.size()) != 0 && t < 20 * BIT) begin
      @(negedge sys_clk);
      t++;
    end
    check("frames_pending", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
